// File: rtl/galvani_frame_parser.sv
// galvani_frame_parser: locks onto sync-framed 8-byte parameter frames,
// validates the XOR checksum, queues good frames in a small FIFO and
// presents the head frame as registered parameter outputs on TX_START.
module galvani_frame_parser #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 255,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] BYTE_IN,
   input  logic       BYTE_VALID,
   input  logic       TX_START,
   output logic       MODE,
   output logic       BIAS_SEL,
   output logic [6:0] BIAS_AMP,
   output logic [4:0] ADDR,
   output logic [7:0] AMP0,
   output logic [7:0] AMP1,
   output logic [7:0] AMP2,
   output logic [7:0] AMP3,
   output logic       FIFO_FULL,
   output logic       FIFO_EMPTY,
   output logic       FRAME_ERR,
   output logic [7:0] ERR_CNT,
   output logic       UNDERRUN
);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned IW = $clog2(TIMEOUT + 1);
   // frame word: [45] mode, [44] bias_sel, [43:39] addr, [38:32] bias_amp,
   // [31:24] amp0, [23:16] amp1, [15:8] amp2, [7:0] amp3
   localparam int unsigned FW = 46;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_CHECK} state_t;

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [IW-1:0]   idle_q, idle_d;
   logic [FW-1:0]   shadow_q, shadow_d;
   logic [7:0]      csum_q, csum_d;
   logic [FW-1:0]   mem_q [FIFO_DEPTH];
   logic [FW-1:0]   mem_d [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   out_q, out_d;
   logic            ferr_q, ferr_d;
   logic [7:0]      err_cnt_q, err_cnt_d;
   logic            under_q, under_d;

   logic            wr_req, csum_err, tmo, pop, wr_ok, ovf;

   // Parser: hunt for sync, collect B1..B6 with running XOR, check B7; idle timeout aborts
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      csum_d   = csum_q;
      wr_req   = 1'b0;
      csum_err = 1'b0;
      idle_d   = (state_q == S_HUNT || BYTE_VALID) ? '0 : idle_q + IW'(1);
      tmo      = (state_q != S_HUNT) && (idle_q == IDLE_LAST);
      if (tmo || state_q == S_HUNT) begin
         // a byte in the timeout cycle is judged as a fresh hunt byte
         state_d = S_HUNT;
         idle_d  = '0;
         if (BYTE_VALID && BYTE_IN == SYNC_BYTE) begin
            state_d = S_COLLECT;
            idx_d   = 3'd1;
            csum_d  = 8'h00;
         end
      end else if (BYTE_VALID) begin
         if (state_q == S_COLLECT) begin
            csum_d = csum_q ^ BYTE_IN;
            idx_d  = idx_q + 3'd1;
            case (idx_q)
               3'd1: begin
                  shadow_d[45:44] = BYTE_IN[7:6];
                  shadow_d[43:39] = BYTE_IN[4:0];
               end
               3'd2:    shadow_d[38:32] = BYTE_IN[6:0];
               3'd3:    shadow_d[31:24] = BYTE_IN;
               3'd4:    shadow_d[23:16] = BYTE_IN;
               3'd5:    shadow_d[15:8]  = BYTE_IN;
               default: shadow_d[7:0]   = BYTE_IN;
            endcase
            if (idx_q == 3'd6) state_d = S_CHECK;
         end else begin
            state_d = S_HUNT;
            if (BYTE_IN == csum_q) wr_req = 1'b1;
            else                   csum_err = 1'b1;
         end
      end
   end

   // Frame FIFO: write from the parser, pop on TX_START, no same-cycle bypass
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      pop      = TX_START && (cnt_q != '0);
      wr_ok    = wr_req && ((cnt_q != DEPTH_C) || pop);
      ovf      = wr_req && !wr_ok;
      if (wr_ok) begin
         mem_d[wr_ptr_q] = shadow_q;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         out_d    = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (wr_ok && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!wr_ok && pop) cnt_d = cnt_q - CW'(1);
   end

   // Error pulse, saturating error count and sticky underrun flag
   always_comb begin
      ferr_d    = csum_err || tmo || ovf;
      err_cnt_d = err_cnt_q;
      if (ferr_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      under_d   = under_q || (TX_START && cnt_q == '0);
   end

   // Control and output registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= S_HUNT;
         idx_q     <= 3'd0;
         idle_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         out_q     <= '0;
         ferr_q    <= 1'b0;
         err_cnt_q <= 8'h00;
         under_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         idle_q    <= idle_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         ferr_q    <= ferr_d;
         err_cnt_q <= err_cnt_d;
         under_q   <= under_d;
      end
   end

   // Data storage: shadow, checksum and FIFO memory need no reset
   always_ff @(posedge CLK) begin
      shadow_q <= shadow_d;
      csum_q   <= csum_d;
      mem_q    <= mem_d;
   end

   assign MODE       = out_q[45];
   assign BIAS_SEL   = out_q[44];
   assign ADDR       = out_q[43:39];
   assign BIAS_AMP   = out_q[38:32];
   assign AMP0       = out_q[31:24];
   assign AMP1       = out_q[23:16];
   assign AMP2       = out_q[15:8];
   assign AMP3       = out_q[7:0];
   assign FIFO_FULL  = (cnt_q == DEPTH_C);
   assign FIFO_EMPTY = (cnt_q == '0);
   assign FRAME_ERR  = ferr_q;
   assign ERR_CNT    = err_cnt_q;
   assign UNDERRUN   = under_q;

endmodule

// File: tb/tb_galvani_frame_parser.sv
// Bench for galvani_frame_parser: byte-level reference model with queues,
// per-cycle comparison of every output, directed scenarios plus random traffic.
module tb_galvani_frame_parser;
   localparam int         DEPTH = 4;
   localparam int         TMO   = 255;
   localparam logic [7:0] SYNC  = 8'hA5;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] BYTE_IN = 8'h00;
   logic       BYTE_VALID = 1'b0;
   logic       TX_START = 1'b0;
   logic       MODE, BIAS_SEL, FIFO_FULL, FIFO_EMPTY, FRAME_ERR, UNDERRUN;
   logic [6:0] BIAS_AMP;
   logic [4:0] ADDR;
   logic [7:0] AMP0, AMP1, AMP2, AMP3, ERR_CNT;

   int checks = 0;
   int failures = 0;
   bit rnd_mode = 1'b0;

   galvani_frame_parser #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .SYNC_BYTE(SYNC)) dut (
      .CLK(CLK), .RST(RST), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .TX_START(TX_START),
      .MODE(MODE), .BIAS_SEL(BIAS_SEL), .BIAS_AMP(BIAS_AMP), .ADDR(ADDR),
      .AMP0(AMP0), .AMP1(AMP1), .AMP2(AMP2), .AMP3(AMP3),
      .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY), .FRAME_ERR(FRAME_ERR),
      .ERR_CNT(ERR_CNT), .UNDERRUN(UNDERRUN)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // frames held as raw bytes {B1,B2,B3,B4,B5,B6}; fields extracted on compare
   logic [7:0]  fb[$];
   logic [47:0] mq[$];
   bit          in_frame = 1'b0;
   int          gap = 0;
   logic [47:0] m_out = '0;
   bit          m_ferr = 1'b0;
   int          m_errcnt = 0;
   bit          m_under = 1'b0;
   bit          armed = 1'b0;

   task automatic model_step();
      bit err, consumed, wr, do_pop;
      logic [47:0] wv;
      logic [7:0]  x;
      err = 0; consumed = 0; wr = 0; wv = '0;
      if (!RST) begin
         fb.delete(); mq.delete();
         in_frame = 0; gap = 0; m_out = '0; m_ferr = 0; m_errcnt = 0; m_under = 0;
         armed = 1;
         return;
      end
      if (TX_START && mq.size() == 0) m_under = 1;
      do_pop = TX_START && (mq.size() > 0);
      // this cycle is the (gap+1)-th since the last byte
      if (in_frame && gap + 1 >= TMO) begin
         err = 1; in_frame = 0; fb.delete();
      end else if (in_frame && BYTE_VALID) begin
         consumed = 1;
         if (fb.size() < 6) fb.push_back(BYTE_IN);
         else begin
            x = 8'h00;
            foreach (fb[i]) x = x ^ fb[i];
            if (x == BYTE_IN) begin
               wr = 1;
               wv = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
            end else err = 1;
            in_frame = 0; fb.delete();
         end
      end
      if (!in_frame && !consumed && BYTE_VALID && BYTE_IN == SYNC) begin
         in_frame = 1; fb.delete();
      end
      gap = BYTE_VALID ? 0 : gap + 1;
      if (do_pop) m_out = mq.pop_front();
      if (wr) begin
         if (mq.size() < DEPTH) mq.push_back(wv);
         else err = 1;
      end
      m_ferr = err;
      if (err && m_errcnt < 255) m_errcnt++;
   endtask

   always @(posedge CLK) model_step();

   // compare every output on the falling edge, away from the active edge
   always @(negedge CLK) begin
      if (armed) begin
         chk("params", {MODE, BIAS_SEL, ADDR, BIAS_AMP, AMP0, AMP1, AMP2, AMP3},
             {m_out[47], m_out[46], m_out[44:40], m_out[38:32], m_out[31:0]});
         chk("fifo_full", FIFO_FULL, 64'(mq.size() == DEPTH));
         chk("fifo_empty", FIFO_EMPTY, 64'(mq.size() == 0));
         chk("frame_err", FRAME_ERR, 64'(m_ferr));
         chk("err_cnt", ERR_CNT, 64'(m_errcnt));
         chk("underrun", UNDERRUN, 64'(m_under));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input bit v, input logic [7:0] b, input bit tx);
      BYTE_VALID = v;
      BYTE_IN    = b;
      TX_START   = rnd_mode ? ($urandom_range(0, 7) == 0) : tx;
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      RST = 1'b0;
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      RST = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] b6,
                             input bit bad, input bit tx_last);
      logic [7:0] fr[8];
      fr[0] = SYNC; fr[1] = b1; fr[2] = b2; fr[3] = b3;
      fr[4] = b4;   fr[5] = b5; fr[6] = b6;
      fr[7] = b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6 ^ (bad ? 8'h01 : 8'h00);
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, fr[i], (i == 7) && tx_last);
         if (rnd_mode && i < 7) idle($urandom_range(0, 2));
      end
   endtask

   initial begin
      int r;
      // reset state
      do_reset();
      chk("rst_mode", MODE, 0);
      chk("rst_amp0", AMP0, 0);
      chk("rst_empty", FIFO_EMPTY, 1);
      chk("rst_full", FIFO_FULL, 0);

      // basic frame and pop
      send_frame(8'hC3, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0);
      chk("q1_empty", FIFO_EMPTY, 0);
      tick(1'b0, 8'h00, 1'b1);
      chk("f1_mode", MODE, 1);
      chk("f1_bsel", BIAS_SEL, 1);
      chk("f1_addr", ADDR, 5'd3);
      chk("f1_bamp", BIAS_AMP, 7'h40);
      chk("f1_amps", {AMP0, AMP1, AMP2, AMP3}, 32'h11223344);
      chk("f1_empty", FIFO_EMPTY, 1);
      chk("f1_errcnt", ERR_CNT, 0);

      // corrupted checksum
      do_reset();
      send_frame(8'hC3, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44, 1, 0);
      chk("bad_ferr", FRAME_ERR, 1);
      idle(2);
      chk("bad_errcnt", ERR_CNT, 1);
      chk("bad_empty", FIFO_EMPTY, 1);
      chk("bad_amp0", AMP0, 0);

      // garbage, valid frame, then timeout of a partial frame
      do_reset();
      tick(1'b1, 8'h00, 0); tick(1'b1, 8'hFF, 0); tick(1'b1, 8'h5A, 0);
      send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 0, 0);
      chk("garb_errcnt", ERR_CNT, 0);
      chk("garb_empty", FIFO_EMPTY, 0);
      tick(1'b1, SYNC, 0); tick(1'b1, 8'h81, 0); tick(1'b1, 8'h12, 0); tick(1'b1, 8'h34, 0);
      idle(TMO + 3);
      chk("tmo_errcnt", ERR_CNT, 1);
      // partial frame again; next frame's sync lands in the timeout cycle
      tick(1'b1, SYNC, 0); tick(1'b1, 8'h81, 0);
      idle(TMO - 1);
      send_frame(8'h9F, 8'h7F, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 0);
      chk("tmo2_errcnt", ERR_CNT, 2);
      chk("tmo2_full", FIFO_FULL, 0);

      // overflow: five frames, four pops in order
      do_reset();
      for (int k = 0; k < 5; k++) begin
         send_frame(8'h00, 8'h00, 8'(8'h10 + k), 8'h00, 8'h00, 8'h00, 0, 0);
         if (k == 3) chk("ovf_full4", FIFO_FULL, 1);
      end
      idle(1);
      chk("ovf_errcnt", ERR_CNT, 1);
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 8'h00, 1'b1);
         chk("ovf_order", AMP0, 64'(8'h10 + k));
      end
      chk("ovf_empty", FIFO_EMPTY, 1);

      // write into a full FIFO with a simultaneous pop
      do_reset();
      for (int k = 0; k < 4; k++) send_frame(8'h00, 8'h00, 8'(8'h20 + k), 8'h00, 8'h00, 8'h00, 0, 0);
      send_frame(8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 0, 1);
      chk("wp_full", FIFO_FULL, 1);
      chk("wp_ferr", FRAME_ERR, 0);
      chk("wp_amp0", AMP0, 8'h20);
      chk("wp_errcnt", ERR_CNT, 0);

      // underrun, then reset mid-frame
      do_reset();
      tick(1'b0, 8'h00, 1'b1);
      chk("und_set", UNDERRUN, 1);
      chk("und_amp0", AMP0, 0);
      send_frame(8'hC3, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0);
      tick(1'b0, 8'h00, 1'b1);
      chk("und_sticky", UNDERRUN, 1);
      tick(1'b1, SYNC, 0); tick(1'b1, 8'h45, 0); tick(1'b1, 8'h12, 0);
      do_reset();
      chk("mid_amp0", AMP0, 0);
      chk("mid_under", UNDERRUN, 0);
      send_frame(8'h05, 8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 0, 0);
      tick(1'b0, 8'h00, 1'b1);
      chk("mid_addr", ADDR, 5'd5);
      chk("mid_bamp", BIAS_AMP, 7'h7E);
      chk("mid_amps", {AMP0, AMP1, AMP2, AMP3}, 32'h01020304);

      // random traffic against the model
      rnd_mode = 1'b1;
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 19);
         if (r < 12) begin
            send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom), (r == 11), 1'b0);
         end else if (r < 15) begin
            for (int j = 0; j < $urandom_range(1, 4); j++) tick(1'b1, 8'($urandom), 1'b0);
         end else if (r == 15) begin
            tick(1'b1, SYNC, 1'b0);
            for (int j = 0; j < $urandom_range(0, 6); j++) tick(1'b1, 8'($urandom), 1'b0);
            idle($urandom_range(TMO - 3, TMO + 2));
         end else if (r == 16 && n % 40 == 7) begin
            RST = 1'b0;
            tick(1'b0, 8'h00, 1'b0);
            RST = 1'b1;
         end else begin
            idle($urandom_range(0, 10));
         end
      end
      rnd_mode = 1'b0;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
